// File: rtl/phy_rx_pkg.sv
// Shared constants for the PHY receive path.
// Idle symbol, lock threshold and aligner state encoding.
package phy_rx_pkg;

  localparam logic [7:0] COM_DEF     = 8'hBC;
  localparam int         BC_LOCK_DEF = 4;

  localparam logic [1:0] ST_SEARCH = 2'd0;
  localparam logic [1:0] ST_COUNT  = 2'd1;
  localparam logic [1:0] ST_ACTIVE = 2'd2;

endpackage

// File: rtl/serial_paralelo_rx.sv
// Serial-to-parallel receiver with COM-based byte alignment.
// Locks after BC_LOCK aligned COM bytes; lock is sticky until reset.
module serial_paralelo_rx
  import phy_rx_pkg::*;
#(
  parameter logic [7:0] COM     = COM_DEF,
  parameter int         BC_LOCK = BC_LOCK_DEF
) (
  input  logic       clk_32f,
  input  logic       reset_L,
  input  logic       data_in,
  output logic [7:0] data_000,
  output logic       valid_000,
  output logic       active
);

  localparam int             BCW    = $clog2(BC_LOCK + 1);
  localparam logic [BCW-1:0] LOCK_V = BCW'(BC_LOCK);

  logic [7:0]     r_shift;
  logic [1:0]     r_state;
  logic [2:0]     r_bit_cnt;
  logic [BCW-1:0] r_bc_cnt;
  logic [7:0]     r_data;
  logic           r_valid;
  logic           r_active;

  logic [7:0]     w_win;
  logic           w_com;
  logic           w_bnd;
  logic [BCW-1:0] w_bc_inc;

  assign w_win    = {r_shift[6:0], data_in};
  assign w_com    = (w_win == COM);
  assign w_bnd    = (r_bit_cnt == 3'd7);
  assign w_bc_inc = (r_bc_cnt == LOCK_V) ? r_bc_cnt
                                         : r_bc_cnt + 1'b1;

  always_ff @(posedge clk_32f or negedge reset_L) begin
    if (!reset_L) begin
      r_shift   <= 8'h00;
      r_state   <= ST_SEARCH;
      r_bit_cnt <= 3'd0;
      r_bc_cnt  <= '0;
      r_data    <= 8'h00;
      r_valid   <= 1'b0;
      r_active  <= 1'b0;
    end else begin
      r_shift <= w_win;
      unique case (r_state)
        ST_SEARCH: begin
          // any bit position may start a byte
          if (w_com) begin
            r_bit_cnt <= 3'd0;
            r_bc_cnt  <= BCW'(1);
            if (LOCK_V <= BCW'(1)) begin
              r_state  <= ST_ACTIVE;
              r_active <= 1'b1;
            end else begin
              r_state <= ST_COUNT;
            end
          end
        end
        ST_COUNT: begin
          r_bit_cnt <= r_bit_cnt + 3'd1;
          if (w_bnd) begin
            if (w_com) begin
              r_bc_cnt <= w_bc_inc;
              if (w_bc_inc == LOCK_V) begin
                r_state  <= ST_ACTIVE;
                r_active <= 1'b1;
              end
            end else begin
              r_state   <= ST_SEARCH;
              r_bc_cnt  <= '0;
              r_bit_cnt <= 3'd0;
            end
          end
        end
        ST_ACTIVE: begin
          r_bit_cnt <= r_bit_cnt + 3'd1;
          if (w_bnd) begin
            r_data  <= w_win;
            r_valid <= !w_com;
          end
        end
        default: begin
          r_state   <= ST_SEARCH;
          r_bit_cnt <= 3'd0;
          r_bc_cnt  <= '0;
        end
      endcase
    end
  end

  assign data_000  = r_data;
  assign valid_000 = r_valid;
  assign active    = r_active;

endmodule

// File: tb/tb_serial_paralelo_rx.sv
// Scoreboard bench for serial_paralelo_rx.
// A bit-index reference model predicts outputs per cycle.
module tb_serial_paralelo_rx;
  import phy_rx_pkg::*;

  localparam logic [7:0] COM     = 8'hBC;
  localparam int         BC_LOCK = 4;

  logic       clk_32f = 1'b0;
  logic       reset_L = 1'b0;
  logic       data_in = 1'b0;
  logic [7:0] data_000;
  logic       valid_000;
  logic       active;

  serial_paralelo_rx #(
    .COM     (COM),
    .BC_LOCK (BC_LOCK)
  ) dut (
    .clk_32f   (clk_32f),
    .reset_L   (reset_L),
    .data_in   (data_in),
    .data_000  (data_000),
    .valid_000 (valid_000),
    .active    (active)
  );

  always #5 clk_32f = ~clk_32f;

  typedef struct {
    int         cyc;
    logic [7:0] d;
    logic       v;
    logic       a;
  } ev_t;

  ev_t sb[$];
  int  cyc = 0;
  int  checks = 0;
  int  errors = 0;

  always @(posedge clk_32f) cyc <= cyc + 1;

  logic [7:0] exp_d = 8'h00;
  logic       exp_v = 1'b0;
  logic       exp_a = 1'b0;

  // model: bit history index, alignment origin, COM run length
  logic [7:0] m_win;
  int         m_n;
  int         m_align;
  int         m_run;
  bit         m_lock;
  logic [7:0] m_d;
  logic       m_v;

  task automatic model_reset();
    m_win   = 8'h00;
    m_n     = 0;
    m_align = -1;
    m_run   = 0;
    m_lock  = 0;
    m_d     = 8'h00;
    m_v     = 1'b0;
  endtask

  task automatic model_step(input logic b);
    ev_t e;
    m_win = {m_win[6:0], b};
    if (!m_lock && m_align < 0) begin
      if (m_win == COM) begin
        m_align = m_n;
        m_run   = 1;
        if (m_run >= BC_LOCK) m_lock = 1;
      end
    end else if (m_n > m_align && ((m_n - m_align) % 8) == 0) begin
      if (m_lock) begin
        m_d = m_win;
        m_v = (m_win != COM);
      end else if (m_win == COM) begin
        m_run++;
        if (m_run >= BC_LOCK) m_lock = 1;
      end else begin
        m_align = -1;
        m_run   = 0;
      end
    end
    m_n++;
    e.cyc = cyc + 1;
    e.d   = m_d;
    e.v   = m_v;
    e.a   = m_lock;
    sb.push_back(e);
  endtask

  always @(negedge clk_32f) begin
    if (reset_L) begin
      while (sb.size() > 0 && sb[0].cyc <= cyc) begin
        if (sb[0].cyc < cyc) begin
          errors++;
          $display("FAIL stale_event cyc=%0d got_cyc=%0d",
                   sb[0].cyc, cyc);
        end
        exp_d = sb[0].d;
        exp_v = sb[0].v;
        exp_a = sb[0].a;
        void'(sb.pop_front());
      end
      checks++;
      if ({data_000, valid_000, active} !== {exp_d, exp_v, exp_a}) begin
        errors++;
        $display("FAIL out cyc=%0d got d=%h v=%b a=%b exp d=%h v=%b a=%b",
                 cyc, data_000, valid_000, active, exp_d, exp_v, exp_a);
      end
    end
  end

  task automatic send_bit(input logic b);
    @(negedge clk_32f);
    data_in = b;
    model_step(b);
  endtask

  task automatic send_byte(input logic [7:0] b);
    for (int i = 7; i >= 0; i--) send_bit(b[i]);
  endtask

  task automatic send_com(input int n);
    for (int i = 0; i < n; i++) send_byte(COM);
  endtask

  task automatic do_reset(input string tag);
    @(posedge clk_32f);
    #2 reset_L = 1'b0;
    #1;
    checks++;
    if ({data_000, valid_000, active} !== 10'b0) begin
      errors++;
      $display("FAIL reset_%s got d=%h v=%b a=%b exp 00/0/0",
               tag, data_000, valid_000, active);
    end
    sb.delete();
    exp_d = 8'h00;
    exp_v = 1'b0;
    exp_a = 1'b0;
    model_reset();
    @(negedge clk_32f);
    data_in = 1'b0;
    @(posedge clk_32f);
    #2 reset_L = 1'b1;
  endtask

  initial begin
    logic [7:0] b;
    model_reset();
    repeat (3) @(posedge clk_32f);
    do_reset("init");

    // lock then two payload bytes
    send_com(4);
    send_byte(8'hDD);
    send_byte(8'hEE);
    send_com(1);

    // broken run returns to search
    do_reset("r27");
    send_com(3);
    send_byte(8'h55);
    send_com(4);
    send_byte(8'h99);

    // misaligned start
    do_reset("r28");
    send_bit(1'b1);
    send_bit(1'b0);
    send_com(4);
    send_byte(8'hAA);
    send_byte(8'hBC);
    send_byte(8'h88);

    // comma-like pattern straddling a boundary
    send_byte(8'h0B);
    send_byte(8'hC0);
    send_com(1);

    // reset mid-byte while locked
    send_bit(1'b0);
    send_bit(1'b1);
    send_bit(1'b0);
    do_reset("r30");
    send_com(3);
    send_byte(8'h11);
    send_com(4);
    send_byte(8'h22);

    for (int it = 0; it < 30; it++) begin
      if ($urandom_range(0, 3) == 0) do_reset("rand");
      for (int j = $urandom_range(0, 7); j > 0; j--)
        send_bit(1'($urandom_range(0, 1)));
      if ($urandom_range(0, 2) == 0) begin
        send_com($urandom_range(1, 3));
        send_byte(8'($urandom_range(0, 255)));
      end
      send_com($urandom_range(4, 5));
      for (int j = 0; j < 20; j++) begin
        b = ($urandom_range(0, 3) == 0) ? COM
                                        : 8'($urandom_range(0, 255));
        send_byte(b);
      end
    end

    send_com(2);
    @(posedge clk_32f);
    @(negedge clk_32f);
    #1;
    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL drain left=%0d exp 0", sb.size());
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout cyc=%0d", cyc);
    $fatal(1, "timeout");
  end

endmodule
